// File: rtl/button_reader.sv
// button_reader: per-channel two-flop synchronizer plus tick-based debounce.
// Produces a clean pressed level (1 = pressed) and one-cycle press/release
// pulses per channel. A single prescaler generates the shared debounce tick.
// CLK_HZ/TICK_HZ must be an integer >= 2 and STABLE_TICKS must be >= 1.
module button_reader #(
   parameter int NUM_IN       = 8,
   parameter int CLK_HZ       = 50_000_000,
   parameter int TICK_HZ      = 1000,
   parameter int STABLE_TICKS = 10,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic              clk50,
   input  logic              rst_n,
   input  logic [NUM_IN-1:0] btn_in,
   output logic [NUM_IN-1:0] btn_level,
   output logic [NUM_IN-1:0] btn_press,
   output logic [NUM_IN-1:0] btn_release,
   output logic              any_press
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CW  = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;

   localparam logic [PW-1:0] PRESC_LAST   = PW'(DIV - 1);
   localparam logic [CW-1:0] CNT_LAST     = CW'(STABLE_TICKS - 1);
   // Raw pin level while the button is not pressed.
   localparam logic          RELEASED_PIN = ACTIVE_LOW;

   logic [PW-1:0] presc_reg;
   logic [PW-1:0] presc_next;
   logic          tick;

   // Prescaler wrap and the one-cycle tick at its terminal count
   always_comb begin
      tick       = (presc_reg == PRESC_LAST);
      presc_next = tick ? '0 : presc_reg + PW'(1);
   end

   // Prescaler register; starts at 0 so the first tick lands DIV cycles after reset
   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         presc_reg <= '0;
      end else begin
         presc_reg <= presc_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_IN; gi = gi + 1) begin : g_ch
         logic          sync1_reg;
         logic          sync2_reg;
         logic          s;
         logic [CW-1:0] cnt_reg;
         logic [CW-1:0] cnt_next;
         logic          level_reg;
         logic          level_next;
         logic          press_reg;
         logic          press_next;
         logic          release_reg;
         logic          release_next;

         // Two-flop synchronizer, parked at the released pin level in reset
         always_ff @(posedge clk50 or negedge rst_n) begin
            if (!rst_n) begin
               sync1_reg <= RELEASED_PIN;
               sync2_reg <= RELEASED_PIN;
            end else begin
               sync1_reg <= btn_in[gi];
               sync2_reg <= sync1_reg;
            end
         end

         // Polarity applied after synchronization: s is 1 while pressed
         assign s = sync2_reg ^ ACTIVE_LOW;

         // Debounce: any agreement with the current level clears the count
         // (even on a tick); otherwise count ticks and accept on the last one
         always_comb begin
            cnt_next     = cnt_reg;
            level_next   = level_reg;
            press_next   = 1'b0;
            release_next = 1'b0;
            if (s == level_reg) begin
               cnt_next = '0;
            end else if (tick) begin
               if (cnt_reg == CNT_LAST) begin
                  cnt_next     = '0;
                  level_next   = s;
                  press_next   = s;
                  release_next = ~s;
               end else begin
                  cnt_next = cnt_reg + CW'(1);
               end
            end
         end

         // Debounce state and registered pulses
         always_ff @(posedge clk50 or negedge rst_n) begin
            if (!rst_n) begin
               cnt_reg     <= '0;
               level_reg   <= 1'b0;
               press_reg   <= 1'b0;
               release_reg <= 1'b0;
            end else begin
               cnt_reg     <= cnt_next;
               level_reg   <= level_next;
               press_reg   <= press_next;
               release_reg <= release_next;
            end
         end

         assign btn_level[gi]   = level_reg;
         assign btn_press[gi]   = press_reg;
         assign btn_release[gi] = release_reg;
      end
   endgenerate

   assign any_press = |btn_press;

endmodule

// File: doc/button_reader.md
# button_reader

Debounced pushbutton/switch input block: the input-side counterpart of the board's free-running LED counter outputs. Samples up to NUM_IN raw mechanical inputs from the 50 MHz domain. Synchronizes and debounces each input on a shared millisecond-scale tick. Produces a clean level per input plus one-cycle press and release pulses, suitable for directly driving counter enables such as `ena1`.

## Interface
- `NUM_IN`, 8, number of input channels.
- `CLK_HZ`, 50_000_000, `clk50` frequency in Hz.
- `TICK_HZ`, 1000, debounce sample tick rate in Hz.
  - DIV = CLK_HZ/TICK_HZ.
  - DIV must be an integer ≥ 2.
- `STABLE_TICKS`, 10, number of consecutive ticks an input must hold a new value before it is accepted. Must be ≥ 1.
- `ACTIVE_LOW`, 1, when 1 the raw pin reads 0 while pressed; when 0 it reads 1 while pressed.

Ports:
- `clk50`  in  1  system clock. All logic is on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `btn_in`  in  NUM_IN  raw asynchronous pin levels.
- `btn_level`  out  NUM_IN  debounced pressed state, 1 = pressed.
- `btn_press`  out  NUM_IN  one-cycle pulse per channel on accepted release→press.
- `btn_release`  out  NUM_IN  one-cycle pulse per channel on accepted press→release.
- `any_press`  out  1  OR of all `btn_press` bits, same cycle.

## Operation
- **Prescaler:**
  - Counts 0..DIV-1 and wraps to 0.
  - Internal `tick` is 1 for exactly the one cycle in which the prescaler equals DIV-1.
  - Width is clog2(DIV).
- **Synchronizer:**
  - Two flops per channel.
  - Reset value is the released raw level: 1 if ACTIVE_LOW, else 0.
  - Polarity is applied after the second flop, giving `s` with 1 = pressed.
- **Debounce counter:**
  - One counter per channel, width clog2(STABLE_TICKS+1).
  - If `s == btn_level`: counter is cleared to 0 on every cycle, whether or not `tick` is high.
  - If `s != btn_level` and `tick` is high:
    - counter < STABLE_TICKS-1: counter increments.
    - counter == STABLE_TICKS-1: `btn_level` toggles and the counter clears.
  - If `s != btn_level` and `tick` is low: counter holds.
- **Pulses:**
  - On the edge where `btn_level` goes 0→1, `btn_press` is 1 for exactly that one following cycle.
  - On the edge where `btn_level` goes 1→0, `btn_release` is 1 for exactly that one following cycle.
  - Pulses are registered and coincide with the new `btn_level` value.
- **Independence:** channels are fully independent. Any number of channels may pulse in the same cycle.
- **Registering:** all outputs are registered, except `any_press`, which is a combinational OR of registered bits.

## Timing
- **Reset values** (asynchronous, while `rst_n` = 0):
  - `btn_level`, `btn_press`, `btn_release`, `any_press` = 0.
  - Prescaler = 0.
  - All debounce counters = 0.
  - Synchronizer flops = released level.
- **Latency.** Take a clean input step with no bounce. From the cycle the new value appears at the second synchronizer flop, `btn_level` updates on the STABLE_TICKS-th subsequent tick. That is between (STABLE_TICKS-1)·DIV+1 and STABLE_TICKS·DIV cycles. Add 2 cycles of synchronizer latency from the pin.
- **Bounce.** Any cycle where `s` returns to `btn_level` clears the counter, and accumulation restarts from 0.
- **Simultaneous events.** If `tick` and the return of `s` to `btn_level` occur in the same cycle, the clear wins. No toggle and no pulse.
- **Pulse width.** A pulse never exceeds 1 cycle. The minimum spacing between a press and the following release on one channel is STABLE_TICKS ticks.
- **Reset mid-debounce.** Partial counts are discarded and no pulse is emitted.
- **Held input across reset.** If an input is held pressed through reset deassertion, it is debounced from the released state. `btn_press` then fires once after the normal latency.
- **Prescaler phase.** After reset, the first `tick` occurs on the DIV-th cycle after `rst_n` rises.

## Test plan
Bench parameters: CLK_HZ=1000, TICK_HZ=100 (DIV=10), STABLE_TICKS=3, NUM_IN=4, ACTIVE_LOW=1.

1. **Reset state and tick phase.**
   - Stimulus: hold `btn_in`=4'b1111 through and after reset.
   - Required: all outputs 0 throughout. Internal `tick` first pulses 10 cycles after `rst_n` rises, then every 10 cycles.
2. **Clean press on channel 0.**
   - Stimulus: drop `btn_in[0]` to 0 and hold.
   - Required: `btn_level[0]` rises 21–30 cycles after the pin changes, plus 2 cycles of synchronizer latency. `btn_press[0]` and `any_press` are high for exactly that cycle. No other channel changes.
3. **Bounce rejection.**
   - Stimulus: on channel 1, toggle the pin low for 15 cycles, high for 1 cycle, low for 15 cycles, then high.
   - Required: `btn_level[1]` stays 0 and no pulses occur. Then hold the pin low for 40 cycles; exactly one `btn_press[1]` occurs.
4. **Release.**
   - Stimulus: from the pressed state in scenario 2, return `btn_in[0]` to 1.
   - Required: `btn_level[0]` falls after 21–32 cycles. `btn_release[0]` is a single 1-cycle pulse. `btn_press` stays 0.
5. **Simultaneous channels.**
   - Stimulus: drop channels 2 and 3 on the same cycle.
   - Required: `btn_press`=4'b1100 for one identical cycle. `any_press`=1 for that one cycle only.
6. **Reset mid-debounce and held-through-reset.**
   - Stimulus: assert `rst_n`=0 for 3 cycles, 15 cycles into a channel 0 press, with the pin kept low.
   - Required: outputs clear immediately. After `rst_n` rises, `btn_press[0]` fires once, 21–32 cycles later.
